// File: rtl/lfsr_checker.sv
// Receive-side XNOR LFSR sequence checker: SEARCH/VERIFY/LOCKED acquisition with flywheel tracking.
// Define LFSR_CHK_PERIOD_EN to build the sequence-period measurement outputs.
module lfsr_checker #(
  parameter int NUM_BITS = 16,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Valid,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear_Count,
  output logic                o_Locked,
  output logic                o_Error,
  output logic [15:0]         o_Err_Count,
  output logic                o_Period_Done,
  output logic [31:0]         o_Period_Len
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam int MW  = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int SW  = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);
  localparam logic [NUM_BITS-1:0] ONES = '1;

  function automatic logic [31:0] st(input int k);
    return 32'd1 << (k - 1);
  endfunction

  // XAPP052 XNOR taps; stage k sits at bit k-1, zero mask for unsupported widths
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      3:  return st(3) | st(2);
      4:  return st(4) | st(3);
      5:  return st(5) | st(3);
      6:  return st(6) | st(5);
      7:  return st(7) | st(6);
      8:  return st(8) | st(6) | st(5) | st(4);
      9:  return st(9) | st(5);
      10: return st(10) | st(7);
      11: return st(11) | st(9);
      12: return st(12) | st(6) | st(4) | st(1);
      13: return st(13) | st(4) | st(3) | st(1);
      14: return st(14) | st(5) | st(3) | st(1);
      15: return st(15) | st(14);
      16: return st(16) | st(15) | st(13) | st(4);
      17: return st(17) | st(14);
      18: return st(18) | st(11);
      19: return st(19) | st(6) | st(2) | st(1);
      20: return st(20) | st(17);
      21: return st(21) | st(19);
      22: return st(22) | st(21);
      23: return st(23) | st(18);
      24: return st(24) | st(23) | st(22) | st(17);
      25: return st(25) | st(22);
      26: return st(26) | st(6) | st(2) | st(1);
      27: return st(27) | st(5) | st(2) | st(1);
      28: return st(28) | st(25);
      29: return st(29) | st(27);
      30: return st(30) | st(6) | st(4) | st(1);
      31: return st(31) | st(28);
      32: return st(32) | st(22) | st(2) | st(1);
      default: return 32'd0;
    endcase
  endfunction

  localparam logic [31:0] TAPS = tap_mask(NUM_BITS);

  function automatic logic [NUM_BITS-1:0] nxt(input logic [NUM_BITS-1:0] w);
    logic [31:0] wx;
    logic        fb;
    wx = '0;
    wx[NUM_BITS-1:0] = w;
    fb = (TAPS != 32'd0) ? ~^(wx & TAPS) : 1'b0;
    return {w[NUM_BITS-2:0], fb};
  endfunction

  logic [1:0]          state_q, state_d;
  logic [NUM_BITS-1:0] exp_q, exp_d;
  logic [MW-1:0]       match_q, match_d;
  logic [SW-1:0]       miss_q, miss_d;
  logic                locked_q;
  logic                err_q, err_d;
  logic [15:0]         errcnt_q, errcnt_d;
  logic                word_ok;
  logic                match_hit, miss_hit;

  assign word_ok   = (i_Data == exp_q);
  assign match_hit = (int'(match_q) + 1) == LOCK_CNT;
  assign miss_hit  = (int'(miss_q) + 1) == LOSS_CNT;

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;
    if (i_Valid) begin
      case (state_q)
        S_LOCKED: begin
          // flywheel: expected advances whether or not the word matched
          exp_d = nxt(exp_q);
          if (word_ok) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_q + 1'b1;
            if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
            if (miss_hit) state_d = S_SEARCH;
          end
        end
        default: begin
          if (state_q == S_VERIFY && word_ok) begin
            exp_d   = nxt(i_Data);
            match_d = match_q + 1'b1;
            if (match_hit) begin
              state_d = S_LOCKED;
              miss_d  = '0;
            end
          end else if (i_Data != ONES) begin
            exp_d   = nxt(i_Data);
            match_d = '0;
            state_d = S_VERIFY;
          end else begin
            state_d = S_SEARCH;
          end
        end
      endcase
    end
    if (i_Clear_Count) errcnt_d = '0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= S_SEARCH;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= (state_d == S_LOCKED);
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign o_Locked    = locked_q;
  assign o_Error     = err_q;
  assign o_Err_Count = errcnt_q;

`ifdef LFSR_CHK_PERIOD_EN
  logic [NUM_BITS-1:0] ref_q, ref_d;
  logic [31:0]         pcnt_q, pcnt_d;
  logic [31:0]         plen_q, plen_d;
  logic                pdone_q, pdone_d;

  // the reference is the word that completed acquisition
  always_comb begin
    ref_d   = ref_q;
    pcnt_d  = pcnt_q;
    plen_d  = plen_q;
    pdone_d = 1'b0;
    if (state_q == S_VERIFY && state_d == S_LOCKED) begin
      ref_d  = exp_q;
      pcnt_d = '0;
    end else if (i_Valid && state_q == S_LOCKED) begin
      pcnt_d = pcnt_q + 32'd1;
      if (word_ok && i_Data == ref_q) begin
        pdone_d = 1'b1;
        plen_d  = pcnt_q + 32'd1;
        pcnt_d  = '0;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ref_q   <= '0;
      pcnt_q  <= '0;
      plen_q  <= '0;
      pdone_q <= 1'b0;
    end else begin
      ref_q   <= ref_d;
      pcnt_q  <= pcnt_d;
      plen_q  <= plen_d;
      pdone_q <= pdone_d;
    end
  end

  assign o_Period_Done = pdone_q;
  assign o_Period_Len  = plen_q;
`else
  assign o_Period_Done = 1'b0;
  assign o_Period_Len  = 32'd0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: 16-bit instance under directed + random stimulus, 4-bit instance for period.
module tb_lfsr_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_vld, a_clr;
  logic [15:0] a_data;
  logic        a_locked, a_err, a_pdone;
  logic [15:0] a_errcnt;
  logic [31:0] a_plen;

  logic        b_rst, b_vld, b_clr;
  logic [3:0]  b_data;
  logic        b_locked, b_err, b_pdone;
  logic [15:0] b_errcnt;
  logic [31:0] b_plen;

  lfsr_checker #(.NUM_BITS(16), .LOCK_CNT(4), .LOSS_CNT(3)) dut_a (
    .i_Clk(clk), .i_Rst(a_rst), .i_Valid(a_vld), .i_Data(a_data), .i_Clear_Count(a_clr),
    .o_Locked(a_locked), .o_Error(a_err), .o_Err_Count(a_errcnt),
    .o_Period_Done(a_pdone), .o_Period_Len(a_plen));

  lfsr_checker #(.NUM_BITS(4), .LOCK_CNT(4), .LOSS_CNT(3)) dut_b (
    .i_Clk(clk), .i_Rst(b_rst), .i_Valid(b_vld), .i_Data(b_data), .i_Clear_Count(b_clr),
    .o_Locked(b_locked), .o_Error(b_err), .o_Err_Count(b_errcnt),
    .o_Period_Done(b_pdone), .o_Period_Len(b_plen));

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;
  logic b_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: next word straight from the shift-and-XNOR rule with the tap stages listed
  function automatic logic [31:0] mnext(input int n, input logic [31:0] w);
    logic p;
    if (n == 16) p = w[15] ^ w[14] ^ w[12] ^ w[3];
    else         p = w[3] ^ w[2];
    return ((w << 1) | {31'b0, ~p}) & ((32'd1 << n) - 32'd1);
  endfunction

  // Model state per instance: 0 = searching, 1 = verifying, 2 = locked
  int          m_st[2], m_match[2], m_miss[2];
  logic [31:0] m_exp[2], m_ref[2], m_cnt[2], m_plen[2];
  logic [15:0] m_err[2];
  logic        m_errp[2], m_pd[2];

  task automatic mstep(input int k, input int n, input logic rst, input logic vld,
                       input logic [31:0] d, input logic clr);
    logic [31:0] ones;
    ones = (32'd1 << n) - 32'd1;
    if (rst) begin
      m_st[k] = 0; m_match[k] = 0; m_miss[k] = 0; m_exp[k] = 0; m_ref[k] = 0;
      m_cnt[k] = 0; m_plen[k] = 0; m_err[k] = 0; m_errp[k] = 0; m_pd[k] = 0;
      return;
    end
    m_errp[k] = 0;
    m_pd[k]   = 0;
    if (vld) begin
      if (m_st[k] == 2) begin
        m_cnt[k]++;
        if (d == m_exp[k]) begin
          m_miss[k] = 0;
          if (d == m_ref[k]) begin
            m_pd[k] = 1; m_plen[k] = m_cnt[k]; m_cnt[k] = 0;
          end
        end else begin
          m_errp[k] = 1;
          if (m_err[k] != 16'hFFFF) m_err[k]++;
          m_miss[k]++;
          if (m_miss[k] == 3) m_st[k] = 0;
        end
        m_exp[k] = mnext(n, m_exp[k]);
      end else if (m_st[k] == 1 && d == m_exp[k]) begin
        m_match[k]++;
        if (m_match[k] == 4) begin
          m_st[k] = 2; m_miss[k] = 0; m_ref[k] = d; m_cnt[k] = 0;
        end
        m_exp[k] = mnext(n, d);
      end else if (d != ones) begin
        m_exp[k] = mnext(n, d); m_match[k] = 0; m_st[k] = 1;
      end else begin
        m_st[k] = 0;
      end
    end
    if (clr) m_err[k] = 0;
  endtask

  always @(posedge clk) begin
    mstep(0, 16, a_rst, a_vld, {16'b0, a_data}, a_clr);
    mstep(1, 4, b_rst, b_vld, {28'b0, b_data}, b_clr);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_locked", {31'b0, a_locked}, {31'b0, m_st[0] == 2});
      chk("a_error",  {31'b0, a_err},    {31'b0, m_errp[0]});
      chk("a_errcnt", {16'b0, a_errcnt}, {16'b0, m_err[0]});
      chk("b_locked", {31'b0, b_locked}, {31'b0, m_st[1] == 2});
      chk("b_errcnt", {16'b0, b_errcnt}, {16'b0, m_err[1]});
`ifdef LFSR_CHK_PERIOD_EN
      chk("a_pdone", {31'b0, a_pdone}, {31'b0, m_pd[0]});
      chk("a_plen",  a_plen, m_plen[0]);
      chk("b_pdone", {31'b0, b_pdone}, {31'b0, m_pd[1]});
      chk("b_plen",  b_plen, m_plen[1]);
`else
      chk("a_pdone", {31'b0, a_pdone}, 32'd0);
      chk("a_plen",  a_plen, 32'd0);
      chk("b_pdone", {31'b0, b_pdone}, 32'd0);
      chk("b_plen",  b_plen, 32'd0);
`endif
    end
  end

  task automatic cyc(input logic rst, input logic vld, input logic [15:0] d, input logic clr);
    a_rst = rst; a_vld = vld; a_data = d; a_clr = clr;
    @(negedge clk);
  endtask

  logic [31:0] tx;

  task automatic sendtx();
    cyc(1'b0, 1'b1, tx[15:0], 1'b0);
    tx = mnext(16, tx);
  endtask

  task automatic sendbad(input logic clr);
    cyc(1'b0, 1'b1, tx[15:0] ^ 16'h0001, clr);
    tx = mnext(16, tx);
  endtask

  // 4-bit instance: continuous sequence from seed 1 for the period measurement
  initial begin
    logic [31:0] t4;
    int pulses;
    b_rst = 1'b1; b_vld = 1'b0; b_data = 4'h0; b_clr = 1'b0;
    pulses = 0;
    @(negedge clk); @(negedge clk);
    b_rst = 1'b0;
    t4 = 32'd1;
    for (int i = 0; i < 50; i++) begin
      b_vld = 1'b1; b_data = t4[3:0];
      t4 = mnext(4, t4);
      @(negedge clk);
      if (b_pdone) pulses++;
    end
    b_vld = 1'b0;
    @(negedge clk);
`ifdef LFSR_CHK_PERIOD_EN
    chk("b_period_len_15", b_plen, 32'd15);
    chk("b_period_pulses", pulses, 32'd3);
`else
    chk("b_period_len_off", b_plen, 32'd0);
    chk("b_period_pulses_off", pulses, 32'd0);
`endif
    b_done = 1'b1;
  end

  initial begin
    int r;
    logic [15:0] d;
    logic vld, rst, clr;
    a_rst = 1'b1; a_vld = 1'b0; a_data = 16'h0; a_clr = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    chk_en = 1'b1;
    chk("rst_locked", {31'b0, a_locked}, 32'd0);
    chk("rst_errcnt", {16'b0, a_errcnt}, 32'd0);
    chk("model_next_000F", mnext(16, 32'h000F), 32'h001E);

    // acquisition with idle gaps mid-sequence
    tx = 32'h0001;
    sendtx(); sendtx(); sendtx();
    cyc(1'b0, 1'b0, 16'hABCD, 1'b0);
    cyc(1'b0, 1'b0, 16'h1234, 1'b0);
    sendtx();
    chk("not_locked_4th", {31'b0, a_locked}, 32'd0);
    sendtx();
    chk("locked_5th", {31'b0, a_locked}, 32'd1);
    chk("errcnt_0", {16'b0, a_errcnt}, 32'd0);

    // single bit error, flywheel recovers
    sendtx(); sendtx();
    sendbad(1'b0);
    chk("one_err_pulse", {31'b0, a_err}, 32'd1);
    chk("one_err_cnt", {16'b0, a_errcnt}, 32'd1);
    chk("one_err_locked", {31'b0, a_locked}, 32'd1);
    sendtx();
    chk("flywheel_no_err", {31'b0, a_err}, 32'd0);
    chk("flywheel_locked", {31'b0, a_locked}, 32'd1);

    // three consecutive misses lose lock
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    chk("cleared", {16'b0, a_errcnt}, 32'd0);
    sendbad(1'b0); sendbad(1'b0);
    chk("two_miss_locked", {31'b0, a_locked}, 32'd1);
    sendbad(1'b0);
    chk("loss_errcnt", {16'b0, a_errcnt}, 32'd3);
    chk("loss_unlocked", {31'b0, a_locked}, 32'd0);
    for (int i = 0; i < 5; i++) sendtx();
    chk("relock", {31'b0, a_locked}, 32'd1);

    // all-ones ignored, reset during lock
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'hFFFF, 1'b0);
    chk("ones_unlocked", {31'b0, a_locked}, 32'd0);
    for (int i = 0; i < 5; i++) sendtx();
    sendbad(1'b0);
    cyc(1'b1, 1'b1, tx[15:0], 1'b1);
    chk("rst_mid_locked", {31'b0, a_locked}, 32'd0);
    chk("rst_mid_err", {31'b0, a_err}, 32'd0);
    chk("rst_mid_errcnt", {16'b0, a_errcnt}, 32'd0);
    chk("rst_mid_plen", a_plen, 32'd0);

    // saturation and clear-beats-error
    for (int i = 0; i < 5; i++) sendtx();
    #2;
    force dut_a.errcnt_q = 16'hFFFF;
    m_err[0] = 16'hFFFF;
    #1;
    release dut_a.errcnt_q;
    sendbad(1'b0);
    chk("sat_hold", {16'b0, a_errcnt}, 32'h0000FFFF);
    sendbad(1'b1);
    chk("clear_wins", {16'b0, a_errcnt}, 32'd0);
    chk("clear_err_pulse", {31'b0, a_err}, 32'd1);
    sendtx();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      r   = $urandom_range(0, 99);
      vld = (r < 85);
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 49) == 0);
      r   = $urandom_range(0, 99);
      if (r < 82)      d = tx[15:0];
      else if (r < 86) d = 16'hFFFF;
      else if (r < 96) d = tx[15:0] ^ (16'd1 << $urandom_range(0, 15));
      else             d = 16'($urandom);
      if ($urandom_range(0, 499) == 0) tx = {16'b0, 16'($urandom_range(1, 16'hFFFE))};
      else if (vld) tx = mnext(16, tx);
      cyc(rst, vld, d, clr);
    end

    for (int i = 0; i < 200 && !b_done; i++) @(negedge clk);
    chk("b_finished", {31'b0, b_done}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
